// File: rtl/csr_ex_if.sv
// Bus between decode, the CSR execution unit and the CSR register block.
// valid_i/ready_o: an instruction transfers on a rising edge where both are high;
// decode holds valid_i and its fields stable until that edge, and ready_o never
// depends combinationally on valid_i.
interface csr_ex_if;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] csr_addr_i;
  logic [4:0]  rs1_addr_i;
  logic [31:0] rs1_data_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] csr_raddr_o;
  logic [31:0] csr_rdata_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        illegal_o;
  logic        done_o;
  logic        hold_o;

  modport slave (
    input  valid_i, funct3_i, csr_addr_i, rs1_addr_i, rs1_data_i, rd_addr_i, csr_rdata_i,
    output ready_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
           reg_we_o, reg_waddr_o, reg_wdata_o, illegal_o, done_o, hold_o
  );

  modport master (
    output valid_i, funct3_i, csr_addr_i, rs1_addr_i, rs1_data_i, rd_addr_i, csr_rdata_i,
    input  ready_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
           reg_we_o, reg_waddr_o, reg_wdata_o, illegal_o, done_o, hold_o
  );
endinterface

// File: rtl/csr_ex.sv
// Zicsr execution unit: IDLE -> READ -> WRITE per instruction, with read-only
// protection and write suppression for zero-operand set/clear forms.
module csr_ex (
  input  logic       clk,
  input  logic       rst,
  csr_ex_if.slave    bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  f3_q;
  logic [11:0] addr_q;
  logic [4:0]  rs1_addr_q;
  logic [31:0] rs1_data_q;
  logic [4:0]  rd_q;
  logic [31:0] old_q;

  logic [31:0] src;
  logic [31:0] new_val;
  logic        write_intent;
  logic        is_illegal;

  // Only the low 12 address bits name a CSR.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.csr_addr_i[31:12];

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      f3_q       <= 3'd0;
      addr_q     <= 12'd0;
      rs1_addr_q <= 5'd0;
      rs1_data_q <= 32'd0;
      rd_q       <= 5'd0;
      old_q      <= 32'd0;
    end else begin
      if (state == S_IDLE && bus.valid_i) begin
        f3_q       <= bus.funct3_i;
        addr_q     <= bus.csr_addr_i[11:0];
        rs1_addr_q <= bus.rs1_addr_i;
        rs1_data_q <= bus.rs1_data_i;
        rd_q       <= bus.rd_addr_i;
      end
      if (state == S_READ) begin
        old_q <= bus.csr_rdata_i;
      end
    end
  end

  // Operand, new value and legality, all derived from the latched instruction.
  always_comb begin
    src = f3_q[2] ? {27'd0, rs1_addr_q} : rs1_data_q;
    case (f3_q[1:0])
      2'b10:   new_val = old_q | src;
      2'b11:   new_val = old_q & ~src;
      default: new_val = src;
    endcase
    write_intent = (f3_q[1:0] == 2'b01) || (rs1_addr_q != 5'd0);
    is_illegal   = (f3_q[1:0] == 2'b00) || (write_intent && addr_q[11:10] == 2'b11);
  end

  always_comb begin
    state_nx        = state;
    bus.ready_o     = 1'b0;
    bus.hold_o      = 1'b0;
    bus.csr_raddr_o = 32'd0;
    bus.csr_we_o    = 1'b0;
    bus.csr_waddr_o = 32'd0;
    bus.csr_wdata_o = 32'd0;
    bus.reg_we_o    = 1'b0;
    bus.reg_waddr_o = 5'd0;
    bus.reg_wdata_o = 32'd0;
    bus.illegal_o   = 1'b0;
    bus.done_o      = 1'b0;
    // Every output is forced quiet while reset is held, regardless of state.
    if (rst) begin
      bus.hold_o = bus.valid_i || (state != S_IDLE);
      case (state)
        S_IDLE: begin
          bus.ready_o = 1'b1;
          if (bus.valid_i) state_nx = S_READ;
        end
        S_READ: begin
          bus.csr_raddr_o = {20'd0, addr_q};
          state_nx        = S_WRITE;
        end
        S_WRITE: begin
          bus.done_o      = 1'b1;
          bus.illegal_o   = is_illegal;
          bus.csr_waddr_o = {20'd0, addr_q};
          bus.csr_wdata_o = new_val;
          bus.reg_waddr_o = rd_q;
          bus.reg_wdata_o = old_q;
          bus.csr_we_o    = !is_illegal && write_intent;
          bus.reg_we_o    = !is_illegal && (rd_q != 5'd0);
          state_nx        = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ex.sv
// Bench for csr_ex: stub CSR block with a cycle counter, directed scenarios and
// randomized instructions checked against a behavioural Zicsr model.
module tb_csr_ex;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_dbg;
  int         errors = 0;
  int         checks = 0;

  csr_ex_if bus ();

  csr_ex dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- stub CSR block ----------------
  logic [63:0] cyc;
  logic [31:0] stub_mem [4096];

  always @(posedge clk) begin
    if (!rst) begin
      cyc <= 64'h0000_0002_FFFF_FF00;
      for (int i = 0; i < 4096; i++) stub_mem[i] <= 32'd0;
      stub_mem[12'h340] <= 32'h0000_00F0;
    end else begin
      cyc <= cyc + 64'd1;
      if (bus.csr_we_o) stub_mem[bus.csr_waddr_o[11:0]] <= bus.csr_wdata_o;
    end
  end

  always_comb begin
    case (bus.csr_raddr_o[11:0])
      12'hC00: bus.csr_rdata_i = cyc[31:0];
      12'hC80: bus.csr_rdata_i = cyc[63:32];
      default: bus.csr_rdata_i = stub_mem[bus.csr_raddr_o[11:0]];
    endcase
  end

  // ---------------- reference model ----------------
  logic [31:0] model_mem [4096];

  typedef struct {
    logic        illegal;
    logic        csr_we;
    logic        reg_we;
    logic [31:0] nv;
  } exp_t;

  function automatic exp_t ref_model(input logic [2:0] f3, input logic [11:0] a,
                                     input logic [4:0] rs1, input logic [31:0] d,
                                     input logic [4:0] rd, input logic [31:0] old);
    exp_t        e;
    logic [31:0] opnd;
    bit          writes;
    bit          bad;
    opnd   = f3[2] ? {27'd0, rs1} : d;
    writes = 1'b0;
    bad    = 1'b0;
    e.nv   = 32'd0;
    case (f3)
      3'b001, 3'b101: begin writes = 1'b1;       e.nv = opnd;        end
      3'b010, 3'b110: begin writes = (rs1 != 0); e.nv = old | opnd;  end
      3'b011, 3'b111: begin writes = (rs1 != 0); e.nv = old & ~opnd; end
      default: bad = 1'b1;
    endcase
    if (writes && a >= 12'hC00) bad = 1'b1;
    e.illegal = bad;
    e.csr_we  = !bad && writes;
    e.reg_we  = !bad && (rd != 0);
    return e;
  endfunction

  function automatic void model_init();
    for (int i = 0; i < 4096; i++) model_mem[i] = 32'd0;
    model_mem[12'h340] = 32'h0000_00F0;
  endfunction

  function automatic logic [31:0] out_or();
    return {31'd0, bus.ready_o | bus.hold_o | bus.csr_we_o | bus.reg_we_o | bus.illegal_o | bus.done_o}
         | bus.csr_raddr_o | bus.csr_waddr_o | bus.csr_wdata_o | bus.reg_wdata_o | {27'd0, bus.reg_waddr_o};
  endfunction

  // ---------------- driver ----------------
  typedef struct {
    logic        ready_n, hold_n, ready_r, hold_r, ready_w, hold_w;
    logic [31:0] raddr_r;
    logic        busy_r;
    logic [31:0] zero_r;
    logic [63:0] cyc_r;
    logic        done_w, illegal_w, csr_we_w, reg_we_w;
    logic [31:0] waddr_w, wdata_w, reg_wdata_w;
    logic [4:0]  reg_waddr_w;
  } obs_t;

  // Starts at a falling edge in IDLE, ends at the falling edge after WRITE.
  task automatic do_instr(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rs1,
                          input logic [31:0] d, input logic [4:0] rd, output obs_t o);
    bus.funct3_i   = f3;
    bus.csr_addr_i = addr;
    bus.rs1_addr_i = rs1;
    bus.rs1_data_i = d;
    bus.rd_addr_i  = rd;
    bus.valid_i    = 1'b1;
    #1;
    o.ready_n = bus.ready_o;
    o.hold_n  = bus.hold_o;
    @(negedge clk);
    bus.valid_i    = 1'b0;
    bus.funct3_i   = 3'($urandom_range(7, 0));
    bus.csr_addr_i = $urandom;
    bus.rs1_addr_i = 5'($urandom_range(31, 0));
    bus.rs1_data_i = $urandom;
    bus.rd_addr_i  = 5'($urandom_range(31, 0));
    #1;
    o.ready_r = bus.ready_o;
    o.hold_r  = bus.hold_o;
    o.raddr_r = bus.csr_raddr_o;
    o.cyc_r   = cyc;
    o.busy_r  = bus.csr_we_o | bus.reg_we_o | bus.done_o | bus.illegal_o;
    o.zero_r  = bus.csr_waddr_o | bus.csr_wdata_o | bus.reg_wdata_o | {27'd0, bus.reg_waddr_o};
    @(negedge clk);
    #1;
    o.ready_w     = bus.ready_o;
    o.hold_w      = bus.hold_o;
    o.done_w      = bus.done_o;
    o.illegal_w   = bus.illegal_o;
    o.csr_we_w    = bus.csr_we_o;
    o.waddr_w     = bus.csr_waddr_o;
    o.wdata_w     = bus.csr_wdata_o;
    o.reg_we_w    = bus.reg_we_o;
    o.reg_waddr_w = bus.reg_waddr_o;
    o.reg_wdata_w = bus.reg_wdata_o;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    rst            = 1'b0;
    bus.valid_i    = 1'b1;
    bus.funct3_i   = 3'b010;
    bus.csr_addr_i = 32'hABCD_0340;
    bus.rs1_addr_i = 5'd0;
    bus.rs1_data_i = $urandom;
    bus.rd_addr_i  = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      v = out_or();
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_outputs cycle %0d got=%h exp=0", i, v); end
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", bus.ready_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL accept_after_release got=%b exp=0", bus.ready_o); end
    bus.valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL idle_after_first got=%b exp=1", bus.ready_o); end
  endtask

  task automatic test_cycle_read();
    obs_t o;
    do_instr(3'b010, 32'h0000_0C00, 5'd0, $urandom, 5'd5, o);
    checks++; if (o.raddr_r !== 32'h0000_0C00) begin errors++; $display("FAIL cyc_raddr got=%h exp=c00", o.raddr_r); end
    checks++; if (o.reg_we_w !== 1'b1) begin errors++; $display("FAIL cyc_reg_we got=%b exp=1", o.reg_we_w); end
    checks++; if (o.reg_waddr_w !== 5'd5) begin errors++; $display("FAIL cyc_reg_waddr got=%0d exp=5", o.reg_waddr_w); end
    checks++; if (o.reg_wdata_w !== o.cyc_r[31:0]) begin errors++; $display("FAIL cyc_value got=%h exp=%h", o.reg_wdata_w, o.cyc_r[31:0]); end
    checks++; if (o.csr_we_w !== 1'b0) begin errors++; $display("FAIL cyc_csr_we got=%b exp=0", o.csr_we_w); end
    checks++; if (o.illegal_w !== 1'b0) begin errors++; $display("FAIL cyc_illegal got=%b exp=0", o.illegal_w); end
    checks++; if (o.done_w !== 1'b1) begin errors++; $display("FAIL cyc_done got=%b exp=1", o.done_w); end
  endtask

  task automatic test_readonly_write();
    obs_t o;
    do_instr(3'b001, 32'h0000_0C80, 5'd2, $urandom, 5'd1, o);
    checks++; if (o.illegal_w !== 1'b1) begin errors++; $display("FAIL ro_illegal got=%b exp=1", o.illegal_w); end
    checks++; if (o.csr_we_w !== 1'b0) begin errors++; $display("FAIL ro_csr_we got=%b exp=0", o.csr_we_w); end
    checks++; if (o.reg_we_w !== 1'b0) begin errors++; $display("FAIL ro_reg_we got=%b exp=0", o.reg_we_w); end
    checks++; if (o.done_w !== 1'b1) begin errors++; $display("FAIL ro_done got=%b exp=1", o.done_w); end
  endtask

  task automatic test_stub_csr();
    obs_t o;
    do_instr(3'b111, 32'h0000_0340, 5'h10, $urandom, 5'd3, o);
    checks++; if (o.csr_we_w !== 1'b1) begin errors++; $display("FAIL rci_csr_we got=%b exp=1", o.csr_we_w); end
    checks++; if (o.waddr_w !== 32'h340) begin errors++; $display("FAIL rci_waddr got=%h exp=340", o.waddr_w); end
    checks++; if (o.wdata_w !== 32'h0000_00E0) begin errors++; $display("FAIL rci_wdata got=%h exp=e0", o.wdata_w); end
    checks++; if (o.reg_wdata_w !== 32'h0000_00F0) begin errors++; $display("FAIL rci_reg_wdata got=%h exp=f0", o.reg_wdata_w); end
    checks++; if (o.reg_waddr_w !== 5'd3) begin errors++; $display("FAIL rci_reg_waddr got=%0d exp=3", o.reg_waddr_w); end
    do_instr(3'b110, 32'h0000_0340, 5'd0, $urandom, 5'd0, o);
    checks++; if ({o.csr_we_w, o.reg_we_w} !== 2'b00) begin errors++; $display("FAIL rsi0_strobes got=%b exp=00", {o.csr_we_w, o.reg_we_w}); end
    checks++; if ({o.done_w, o.illegal_w} !== 2'b10) begin errors++; $display("FAIL rsi0_done got=%b exp=10", {o.done_w, o.illegal_w}); end
    do_instr(3'b010, 32'hFFFF_F340, 5'd0, $urandom, 5'd7, o);
    checks++; if (o.raddr_r !== 32'h340) begin errors++; $display("FAIL rb_raddr got=%h exp=340", o.raddr_r); end
    checks++; if (o.reg_wdata_w !== 32'h0000_00E0) begin errors++; $display("FAIL rb_value got=%h exp=e0", o.reg_wdata_w); end
    model_mem[12'h340] = 32'h0000_00E0;
  endtask

  task automatic test_illegal_funct3();
    obs_t o;
    logic [2:0] f3;
    for (int k = 0; k < 2; k++) begin
      f3 = (k == 0) ? 3'b100 : 3'b000;
      do_instr(f3, 32'h0000_0340, 5'd5, $urandom, 5'd9, o);
      checks++; if (o.illegal_w !== 1'b1) begin errors++; $display("FAIL f3_%b_illegal got=%b exp=1", f3, o.illegal_w); end
      checks++; if ({o.csr_we_w, o.reg_we_w} !== 2'b00) begin errors++; $display("FAIL f3_%b_strobes got=%b exp=00", f3, {o.csr_we_w, o.reg_we_w}); end
      checks++; if (o.done_w !== 1'b1) begin errors++; $display("FAIL f3_%b_done got=%b exp=1", f3, o.done_w); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] rv_q[$];
    int          acc[$];
    int          hold_bad;
    logic [31:0] d1, d2, old0;
    d1       = $urandom;
    d2       = $urandom;
    old0     = model_mem[12'h341];
    hold_bad = 0;
    exp_q    = {d1, d2};
    bus.funct3_i   = 3'b001;
    bus.csr_addr_i = 32'h0000_0341;
    bus.rs1_addr_i = 5'd1;
    bus.rs1_data_i = d1;
    bus.rd_addr_i  = 5'd4;
    bus.valid_i    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.ready_o && bus.valid_i) acc.push_back(c);
      if (bus.csr_we_o) begin
        got_q.push_back(bus.csr_wdata_o);
        rv_q.push_back(bus.reg_wdata_o);
      end
      if (acc.size() >= 1 && c <= acc[0] + 2 && !bus.hold_o) hold_bad++;
      if (acc.size() == 1 && c == acc[0] + 1) bus.rs1_data_i = d2;
      if (acc.size() == 2 && c == acc[1] + 1) bus.valid_i = 1'b0;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    checks++; if (acc.size() != 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=2", acc.size()); end
    else begin
      checks++; if (acc[1] - acc[0] != 3) begin errors++; $display("FAIL b2b_spacing got=%0d exp=3", acc[1] - acc[0]); end
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL b2b_hold low_cycles=%0d exp=0", hold_bad); end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL b2b_writes got=%0d exp=2", got_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_wdata%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (rv_q[0] !== old0) begin errors++; $display("FAIL b2b_old0 got=%h exp=%h", rv_q[0], old0); end
      checks++; if (rv_q[1] !== d1) begin errors++; $display("FAIL b2b_old1 got=%h exp=%h", rv_q[1], d1); end
    end
    model_mem[12'h341] = d2;
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [2:0]  f3;
    logic [31:0] addr, d, old;
    logic [11:0] a;
    logic [4:0]  rs1, rd;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(7, 0));
      case ($urandom_range(6, 0))
        0: a = 12'h340;
        1: a = 12'h341;
        2: a = 12'h305;
        3: a = 12'hC00;
        4: a = 12'hC80;
        5: a = 12'hC01;
        default: a = 12'($urandom_range(4095, 0));
      endcase
      addr = {20'($urandom), a};
      rs1  = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      rd   = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      d    = $urandom;
      do_instr(f3, addr, rs1, d, rd, o);
      old = (a == 12'hC00) ? o.cyc_r[31:0] : (a == 12'hC80) ? o.cyc_r[63:32] : model_mem[a];
      e   = ref_model(f3, a, rs1, d, rd, old);
      checks++; if ({o.ready_n, o.hold_n, o.ready_r, o.hold_r, o.ready_w, o.hold_w} !== 6'b110101)
        begin errors++; $display("FAIL rnd%0d_ready_hold got=%b exp=110101", n, {o.ready_n, o.hold_n, o.ready_r, o.hold_r, o.ready_w, o.hold_w}); end
      checks++; if (o.raddr_r !== {20'd0, a}) begin errors++; $display("FAIL rnd%0d_raddr got=%h exp=%h", n, o.raddr_r, a); end
      checks++; if (o.busy_r !== 1'b0 || o.zero_r !== 32'd0) begin errors++; $display("FAIL rnd%0d_read_quiet got=%b/%h exp=0/0", n, o.busy_r, o.zero_r); end
      checks++; if ({o.done_w, o.illegal_w} !== {1'b1, e.illegal}) begin errors++; $display("FAIL rnd%0d_done_illegal got=%b exp=%b", n, {o.done_w, o.illegal_w}, {1'b1, e.illegal}); end
      checks++; if (o.csr_we_w !== e.csr_we) begin errors++; $display("FAIL rnd%0d_csr_we got=%b exp=%b", n, o.csr_we_w, e.csr_we); end
      checks++; if (o.reg_we_w !== e.reg_we) begin errors++; $display("FAIL rnd%0d_reg_we got=%b exp=%b", n, o.reg_we_w, e.reg_we); end
      if (e.csr_we) begin
        checks++; if ({o.waddr_w, o.wdata_w} !== {20'd0, a, e.nv}) begin errors++; $display("FAIL rnd%0d_csr_write got=%h:%h exp=%h:%h", n, o.waddr_w, o.wdata_w, a, e.nv); end
        model_mem[a] = e.nv;
      end
      if (e.reg_we) begin
        checks++; if ({o.reg_waddr_w, o.reg_wdata_w} !== {rd, old}) begin errors++; $display("FAIL rnd%0d_reg_write got=%0d:%h exp=%0d:%h", n, o.reg_waddr_w, o.reg_wdata_w, rd, old); end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int          pulses;
    logic [31:0] v;
    pulses = 0;
    bus.funct3_i   = 3'b001;
    bus.csr_addr_i = 32'h0000_0340;
    bus.rs1_addr_i = 5'd3;
    bus.rs1_data_i = 32'h0000_0055;
    bus.rd_addr_i  = 5'd6;
    bus.valid_i    = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst         = 1'b0;
    #1;
    v = out_or();
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL midrst_outputs got=%h exp=0", v); end
    for (int c = 0; c < 3; c++) begin
      if (bus.csr_we_o || bus.reg_we_o) pulses++;
      @(negedge clk);
      #1;
    end
    if (bus.csr_we_o || bus.reg_we_o) pulses++;
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_strobes got=%0d exp=0", pulses); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.ready_o, bus.hold_o} !== 2'b10) begin errors++; $display("FAIL midrst_idle got=%b exp=10", {bus.ready_o, bus.hold_o}); end
    @(negedge clk);
    #1;
    checks++; if ({bus.ready_o, bus.csr_we_o, bus.done_o} !== 3'b100) begin errors++; $display("FAIL midrst_stay_idle got=%b exp=100", {bus.ready_o, bus.csr_we_o, bus.done_o}); end
    model_init();
  endtask

  initial begin
    model_init();
    test_reset();
    test_cycle_read();
    test_readonly_write();
    test_stub_csr();
    test_illegal_funct3();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
